// File: rtl/eth_pkg.sv
// Shared encodings for the GMII/MII receive path: speed modes, preamble/SFD symbols, framer states.
// Pure definitions; no timing or flow-control behaviour.
package eth_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;
  localparam logic [7:0] SFD_BYTE     = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  // 2'b11 is deliberately treated as gigabit.
  function automatic logic is_nib_speed(input logic [1:0] spd);
    return (spd == SPD_10) || (spd == SPD_100);
  endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// Filters RGMII in-band status nibbles; outputs change one cycle after the STATUS_STABLE-th identical sample.
// No backpressure: samples are taken whenever sample_i is high.
module rgmii_inband_status
  import eth_pkg::*;
#(
  parameter int STATUS_STABLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_i,
  input  logic [3:0] nib_i,
  output logic       link_up_o,
  output logic [1:0] link_speed_o,
  output logic       link_fdx_o
);

  localparam int RW = $clog2(STATUS_STABLE + 1);

  logic [3:0]    cand_q, cand_d;
  logic [RW-1:0] run_q, run_d;
  logic [3:0]    stat_q, stat_d;

  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    stat_d = stat_q;
    if (sample_i) begin
      cand_d = nib_i;
      // A zero run length means no candidate yet, so the first sample always starts a run.
      if ((run_q != '0) && (nib_i == cand_q)) begin
        if (run_q != RW'(STATUS_STABLE)) begin
          run_d = run_q + 1'b1;
        end
      end else begin
        run_d = RW'(1);
      end
      if (run_d == RW'(STATUS_STABLE)) begin
        stat_d = nib_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
      run_q  <= '0;
      stat_q <= '0;
    end else begin
      cand_q <= cand_d;
      run_q  <= run_d;
      stat_q <= stat_d;
    end
  end

  assign link_up_o    = stat_q[0];
  assign link_speed_o = stat_q[2:1];
  assign link_fdx_o   = stat_q[3];

endmodule

// File: rtl/gmii_rx_rate_adapter.sv
// GMII/MII receive framer: strips preamble, packs nibbles, emits bytes 2 cycles after sample (eof byte 1 cycle after dv fall).
// No backpressure: the output is a strobe stream that must be consumed as produced.
module gmii_rx_rate_adapter
  import eth_pkg::*;
#(
  parameter int MAX_LEN       = 1522,
  parameter int LEN_W         = 11,
  parameter int CNT_W         = 16,
  parameter int STATUS_STABLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       speed_mode,
  input  logic             in_ce,
  input  logic             in_dv,
  input  logic             in_er,
  input  logic [7:0]       in_d,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             link_fdx,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  rx_state_e        state_q, state_d;
  logic             nib_mode_q, nib_mode_d;
  logic             nib_phase_q, nib_phase_d;
  logic [3:0]       lo_nib_q, lo_nib_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             byte_done;
  logic [7:0]       new_byte;
  logic             enter_data;
  logic             inc_good;
  logic             inc_bad;
  logic             status_smp;

  always_comb begin
    state_d     = state_q;
    nib_mode_d  = nib_mode_q;
    nib_phase_d = nib_phase_q;
    lo_nib_d    = lo_nib_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    first_d     = first_q;
    err_d       = err_q;
    len_d       = len_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    out_err_d   = 1'b0;
    byte_done   = 1'b0;
    new_byte    = in_d;
    enter_data  = 1'b0;
    inc_good    = 1'b0;
    inc_bad     = 1'b0;

    if (in_ce) begin
      case (state_q)
        ST_IDLE: begin
          if (in_dv) begin
            state_d    = ST_PREAMBLE;
            nib_mode_d = is_nib_speed(speed_mode);
            lo_nib_d   = in_d[3:0];
          end
        end

        ST_PREAMBLE: begin
          if (!in_dv) begin
            state_d = ST_IDLE;
          end else if (nib_mode_q) begin
            // lo_nib_q doubles as the previous preamble nibble while hunting for 5-D.
            lo_nib_d = in_d[3:0];
            if ((in_d[3:0] == SFD_NIB) && (lo_nib_q == PREAMBLE_NIB)) begin
              enter_data = 1'b1;
            end
          end else if (in_d == SFD_BYTE) begin
            enter_data = 1'b1;
          end
        end

        ST_DATA: begin
          if (!in_dv) begin
            state_d    = ST_IDLE;
            hold_vld_d = 1'b0;
            if (hold_vld_q) begin
              out_valid_d = 1'b1;
              out_data_d  = hold_q;
              out_sof_d   = first_q;
              out_eof_d   = 1'b1;
              out_err_d   = err_q | nib_phase_q;
              inc_good    = ~(err_q | nib_phase_q);
              inc_bad     = err_q | nib_phase_q;
            end else begin
              inc_bad = 1'b1;
            end
          end else begin
            if (in_er) begin
              err_d = 1'b1;
            end
            if (nib_mode_q) begin
              if (nib_phase_q) begin
                byte_done   = 1'b1;
                new_byte    = {in_d[3:0], lo_nib_q};
                nib_phase_d = 1'b0;
              end else begin
                lo_nib_d    = in_d[3:0];
                nib_phase_d = 1'b1;
              end
            end else begin
              byte_done = 1'b1;
            end

            if (byte_done) begin
              if (hold_vld_q) begin
                out_valid_d = 1'b1;
                out_data_d  = hold_q;
                out_sof_d   = first_q;
                first_d     = 1'b0;
              end
              hold_d     = new_byte;
              hold_vld_d = 1'b1;
              len_d      = len_q + 1'b1;
              if (len_q == LEN_W'(MAX_LEN - 1)) begin
                state_d = ST_DROP;
              end
            end
          end
        end

        ST_DROP: begin
          // The byte that hit the length limit is still held; it closes the frame as bad.
          if (hold_vld_q) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q;
            out_sof_d   = first_q;
            out_eof_d   = 1'b1;
            out_err_d   = 1'b1;
            inc_bad     = 1'b1;
            hold_vld_d  = 1'b0;
            first_d     = 1'b0;
          end
          if (!in_dv) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase

      if (enter_data) begin
        state_d     = ST_DATA;
        nib_phase_d = 1'b0;
        hold_vld_d  = 1'b0;
        first_d     = 1'b1;
        err_d       = 1'b0;
        len_d       = '0;
      end
    end

    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (inc_good && (frame_cnt_q != '1)) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
    if (inc_bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      nib_mode_q  <= 1'b0;
      nib_phase_q <= 1'b0;
      lo_nib_q    <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      nib_mode_q  <= nib_mode_d;
      nib_phase_q <= nib_phase_d;
      lo_nib_q    <= lo_nib_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      first_q     <= first_d;
      err_q       <= err_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Status nibbles are only meaningful between frames with no carrier/error indication.
  assign status_smp = in_ce && (state_q == ST_IDLE) && !in_dv && !in_er;

  rgmii_inband_status #(
    .STATUS_STABLE(STATUS_STABLE)
  ) u_status (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_i     (status_smp),
    .nib_i        (in_d[3:0]),
    .link_up_o    (link_up),
    .link_speed_o (link_speed),
    .link_fdx_o   (link_fdx)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_err   = out_err_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/gmii_rx_rate_adapter.md
Name: gmii_rx_rate_adapter

Overview:
Receive-side successor to the fixed 1000M GMII/RGMII bridge. It sits after the RGMII receiver on the GMII receive clock and accepts SDR GMII data at 1000M, or MII nibbles at 10/100M qualified by a sample enable. It strips preamble/SFD, packs nibbles into bytes, and emits an aligned byte stream with start/end/error framing. It also decodes RGMII in-band link status and keeps saturating frame and error counters.

Parameters:
MAX_LEN, 1522, maximum payload bytes after SFD before truncation
LEN_W, 11, width of internal byte counter (must hold MAX_LEN)
CNT_W, 16, width of frame_cnt and err_cnt
STATUS_STABLE, 4, consecutive identical idle status samples required to update link status

Ports:
clk  in  1  GMII receive clock (125 MHz)
rst_n  in  1  asynchronous active-low reset
speed_mode  in  2  00=10M, 01=100M, 10=1000M, 11 treated as 1000M
in_ce  in  1  sample enable; held 1 at 1000M, one pulse per nibble at 10/100M
in_dv  in  1  GMII/MII data valid
in_er  in  1  GMII/MII receive error
in_d  in  8  data; nibble modes use in_d[3:0]
out_valid  out  1  output byte strobe
out_data  out  8  output byte
out_sof  out  1  first byte of frame (with out_valid)
out_eof  out  1  last byte of frame (with out_valid)
out_err  out  1  frame bad (qualifies the out_eof byte only)
link_up  out  1  decoded in-band link
link_speed  out  2  decoded in-band speed
link_fdx  out  1  decoded in-band duplex
frame_cnt  out  CNT_W  good frames, saturating
err_cnt  out  CNT_W  bad frames, saturating

Behaviour:
- Reset: all outputs 0; FSM to IDLE; hold register empty.
- Only cycles with in_ce=1 are samples. All other cycles change no state, except that outputs return to 0.
- nib_mode = (speed_mode is 00 or 01), latched on the IDLE->PREAMBLE transition. Speed changes mid-frame are ignored.
- FSM states are IDLE, PREAMBLE, DATA, DROP.
- IDLE -> PREAMBLE on a sample with in_dv=1.
- PREAMBLE:
  - Byte mode: the SFD is a byte equal to 0xD5. Go to DATA.
  - Nibble mode: the SFD is nibble 0xD immediately preceded by nibble 0x5. Go to DATA with the nibble phase cleared.
  - in_dv=0 before the SFD: go to IDLE with no output and no count change.
- DATA, byte assembly:
  - Byte mode: each sample is one byte.
  - Nibble mode: the first nibble is the low half, the second is the high half. The byte completes on the second nibble.
- DATA, one-byte hold for eof:
  - When a byte completes and the hold register is full, emit the held byte on the next cycle (out_valid=1). out_sof=1 on the first emitted byte. Then load the new byte into hold.
  - On a sample with in_dv=0 and hold full, emit the held byte with out_eof=1 and go to IDLE.
  - in_dv=0 with hold empty: no output, go to IDLE, and count as a bad frame.
- Latency: at 1000M a byte appears 2 cycles after its sample, or 1 cycle after the dv-low sample for the last byte.
- out_err=1 on the eof byte if any of these occurred: in_er=1 on any DATA sample; odd nibble count at dv fall (the partial nibble is discarded); truncation.
- Truncation: when the MAX_LEN-th byte completes, emit it with out_eof=1 and out_err=1, then go to DROP. DROP waits for an in_dv=0 sample, then goes to IDLE.
- A frame with a single byte emits one beat with out_sof=out_eof=1.
- Counters: each eof increments frame_cnt if out_err=0, else err_cnt. Both saturate at all ones.
- In-band status, sampled on IDLE samples with in_dv=0 and in_er=0:
  - bit0 = link, bits2:1 = speed, bit3 = duplex, taken from in_d[3:0].
  - Outputs update only after STATUS_STABLE consecutive identical samples.
  - Any differing sample restarts the count.
- Reset asserted mid-frame: everything clears immediately. The frame is not emitted and not counted.

Decomposition:
- Shared package eth_pkg: speed_mode encodings (SPD_10, SPD_100, SPD_1000), PREAMBLE_NIB=4'h5, SFD_NIB=4'hD, SFD_BYTE=8'hD5, FSM state encoding.
- One sub-module: rgmii_inband_status (status sampling, stability counter, link outputs).
- The framing FSM, nibble packer and counters stay in the top level.

Test Plan:
- 1000M, in_ce=1: 7×0x55, 0xD5, then bytes 01..40 (64 bytes), dv low. Expect 64 beats 01..40, sof on 01, eof on 40, out_err=0, frame_cnt=1.
- 100M, in_ce every 5th cycle: nibbles 5×14, D, then 0x34 0x12 sent low nibble first. Expect bytes 0x34, 0x12, eof on 0x12, no err.
- 100M: same frame with one extra trailing nibble. Expect the last full byte with eof and out_err=1, err_cnt=1.
- 1000M: in_er pulse on payload byte 10 of 60. Expect all 60 bytes emitted, eof byte has out_err=1.
- MAX_LEN=16 build: 20-byte payload. Expect 16 beats, eof+err on the 16th, no output for the rest, err_cnt=1, then the next good frame is counted normally.
- Idle status: in_d=0x5 for 3 samples, then 0x5 again. Expect link_up=1, link_speed=2, link_fdx=0 only after the 4th. Then a single 0x4 sample changes nothing. Also assert rst_n mid-frame and expect all outputs 0 and counts unchanged.
